// File: rtl/conv_1st_ctrl.sv
// conv_1st_ctrl: job sequencer for conv_1st_data (optional stall counter under CONV_CTRL_PERF_EN)
module conv_1st_ctrl #(
   parameter int W_CYC     = 11,
   parameter int P_PRE     = 60,
   parameter int RUN_CYC   = 1024,
   parameter int DRAIN_CYC = 50,
   parameter int CNT_W     = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic        weight_valid,
   output logic        weight_ready,
   input  logic        pixel_valid,
   output logic        pixel_ready,
   input  logic        conv_ready,
   output logic        conv_valid,
   output logic        en_array,
   output logic        en_DFF_pixel,
   output logic        en_DFF_weight,
   output logic        en_cnt,
   output logic        flush,
   output logic        ud_pixel,
   output logic        ud_weight,
   output logic        busy,
   output logic        done,
   output logic [31:0] stall_cnt
);
   typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_P, RUN, DRAIN, OUT, FLUSH} state_t;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             aborted_q, aborted_d;
   logic             last_w, last_p, last_r, last_d, abortable;
   assign last_w    = cnt_q == CNT_W'(W_CYC - 1);
   assign last_p    = cnt_q == CNT_W'(P_PRE - 1);
   assign last_r    = cnt_q == CNT_W'(RUN_CYC - 1);
   assign last_d    = cnt_q == CNT_W'(DRAIN_CYC - 1);
   assign abortable = state_q != IDLE && state_q != FLUSH;
   // state, beat counter and aborted-job flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         aborted_q <= aborted_d;
      end
   end
   // next state and datapath control decode
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      aborted_d     = aborted_q;
      weight_ready  = 1'b0;
      pixel_ready   = 1'b0;
      conv_valid    = 1'b0;
      en_array      = 1'b0;
      en_DFF_pixel  = 1'b0;
      en_DFF_weight = 1'b0;
      en_cnt        = 1'b0;
      flush         = 1'b0;
      ud_pixel      = 1'b0;
      ud_weight     = 1'b0;
      done          = 1'b0;
      busy          = state_q != IDLE;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = LOAD_W;
               cnt_d     = '0;
               aborted_d = 1'b0;
            end
         end
         LOAD_W: begin
            weight_ready  = 1'b1;
            en_DFF_weight = weight_valid;
            ud_weight     = weight_valid;
            en_cnt        = weight_valid;
            if (weight_valid) begin
               cnt_d   = last_w ? '0 : cnt_q + CNT_W'(1);
               state_d = last_w ? LOAD_P : LOAD_W;
            end
         end
         LOAD_P: begin
            pixel_ready  = 1'b1;
            en_DFF_pixel = pixel_valid;
            ud_pixel     = pixel_valid;
            en_cnt       = pixel_valid;
            if (pixel_valid) begin
               cnt_d   = last_p ? '0 : cnt_q + CNT_W'(1);
               state_d = last_p ? RUN : LOAD_P;
            end
         end
         RUN: begin
            pixel_ready  = 1'b1;
            en_DFF_pixel = pixel_valid;
            ud_pixel     = pixel_valid;
            en_cnt       = pixel_valid;
            en_array     = pixel_valid;
            if (pixel_valid) begin
               cnt_d   = last_r ? '0 : cnt_q + CNT_W'(1);
               state_d = last_r ? DRAIN : RUN;
            end
         end
         DRAIN: begin
            en_array     = 1'b1;
            en_DFF_pixel = 1'b1;
            cnt_d        = last_d ? '0 : cnt_q + CNT_W'(1);
            state_d      = last_d ? OUT : DRAIN;
         end
         OUT: begin
            conv_valid = 1'b1;
            state_d    = conv_ready ? FLUSH : OUT;
         end
         FLUSH: begin
            flush   = 1'b1;
            done    = !aborted_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (abort && abortable) begin
         state_d   = FLUSH;
         cnt_d     = '0;
         aborted_d = 1'b1;
      end
   end
`ifdef CONV_CTRL_PERF_EN
   logic [31:0] stall_q, stall_d;
   logic        stall_ev;
   assign stall_ev  = (state_q == LOAD_W && !weight_valid) ||
                      ((state_q == LOAD_P || state_q == RUN) && !pixel_valid);
   assign stall_d   = (state_q == IDLE && start) ? '0 :
                      (stall_ev && stall_q != '1) ? stall_q + 32'd1 : stall_q;
   assign stall_cnt = stall_q;
   // saturating count of upstream starvation cycles for the current job
   always_ff @(posedge clk) begin
      if (rst) stall_q <= '0;
      else     stall_q <= stall_d;
   end
`else
   assign stall_cnt = '0;
`endif
endmodule

// File: doc/conv_1st_ctrl.md
Name: conv_1st_ctrl

Overview:
- Sequencer for the first-layer convolution datapath (`conv_1st_data`).
- Accepts a start command, then streams 72-bit weight beats into the weight buffer, pre-fills the pixel buffer, and runs the systolic array over a pixel stream.
- Drains the array, presents the 40x32-bit result with a valid/ready handshake, then flushes.
- Drives all datapath control lines: `en_array`, `en_DFF_*`, `en_cnt`, `flush`, `ud_*`.

Parameters:
- W_CYC, 11: weight beats loaded per job.
- P_PRE, 60: pixel beats to pre-fill the pixel buffer before array enable.
- RUN_CYC, 1024: pixel beats streamed with the array enabled.
- DRAIN_CYC, 50: array-enabled cycles after the last pixel, so partial sums settle.
- CNT_W, 16: width of the internal beat/cycle counter; must hold max(W_CYC, P_PRE, RUN_CYC, DRAIN_CYC).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  job request; sampled in IDLE only
- abort  in  1  synchronous abort; ignored in IDLE
- weight_valid  in  1  upstream weight beat present
- weight_ready  out  1  controller accepts weight beat
- pixel_valid  in  1  upstream pixel beat present
- pixel_ready  out  1  controller accepts pixel beat
- conv_ready  in  1  downstream accepts result
- conv_valid  out  1  `conv_o` of datapath is final
- en_array  out  1  systolic array enable
- en_DFF_pixel  out  1  pixel buffer register enable
- en_DFF_weight  out  1  weight buffer register enable
- en_cnt  out  1  buffer address counter enable
- flush  out  1  clear array accumulators
- ud_pixel  out  1  1 = load new pixel, 0 = hold/recirculate
- ud_weight  out  1  1 = load new weight, 0 = hold
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on normal job completion
- stall_cnt  out  32  performance counter (see Optional Feature)

Behaviour:
- Reset and structure:
  - Synchronous reset (`rst`=1 at a clk edge): state=IDLE, counter=0, stall_cnt=0.
  - All outputs are combinational decodes of state, counter and the valid/ready inputs. In IDLE every output is 0, so all outputs read 0 from reset.
- A beat occurs when valid && ready in the same cycle. The counter increments only on beats (LOAD_W, LOAD_P, RUN) or every cycle (DRAIN).
- IDLE:
  - start=1 -> LOAD_W, counter=0.
  - abort is ignored.
  - start while busy is ignored.
- LOAD_W:
  - weight_ready=1.
  - On a beat: en_DFF_weight=1, ud_weight=1, en_cnt=1.
  - Beat with counter==W_CYC-1 -> LOAD_P, counter=0.
- LOAD_P:
  - pixel_ready=1.
  - On a beat: en_DFF_pixel=1, ud_pixel=1, en_cnt=1.
  - Beat with counter==P_PRE-1 -> RUN, counter=0.
- RUN:
  - pixel_ready=1.
  - On a beat: en_DFF_pixel=1, ud_pixel=1, en_cnt=1, en_array=1.
  - en_DFF_weight=0 (weights held).
  - pixel_valid=0 stalls: en_array, en_DFF_pixel and en_cnt are all 0, so the datapath freezes.
  - Beat with counter==RUN_CYC-1 -> DRAIN, counter=0.
- DRAIN:
  - en_array=1, en_DFF_pixel=1, ud_pixel=0, pixel_ready=0.
  - Counter increments every cycle; counter==DRAIN_CYC-1 -> OUT.
- OUT:
  - conv_valid=1; all enables 0.
  - conv_ready=1 -> FLUSH.
  - conv_valid stays asserted until accepted.
- FLUSH:
  - flush=1 for exactly one cycle, then -> IDLE.
  - done=1 in this cycle only if no abort occurred for the job.
- Abort:
  - abort=1 in any state except IDLE or FLUSH -> FLUSH next cycle; done is not pulsed.
  - Outputs in the abort cycle are those of the current state, and any beat is still consumed.
  - abort in FLUSH has no effect.
- Reset mid-operation: returns to IDLE immediately with no flush pulse; the datapath is cleared by its own reset.
- Simultaneous valid in a non-accepting state: ready=0, no beat.

Optional Feature:
- Macro: CONV_CTRL_PERF_EN.
- Defined:
  - stall_cnt increments (saturating at 2^32-1) each cycle in LOAD_W with weight_valid=0, or in LOAD_P/RUN with pixel_valid=0.
  - Cleared to 0 on the cycle start is accepted, and by reset.
- Undefined: stall_cnt is tied to 0 and no counter logic exists. The port stays present so the interface is identical.

Test Plan:
- W_CYC=11, P_PRE=60, RUN_CYC=8, DRAIN_CYC=4; start pulse with valids always high:
  - weight_ready high for 11 cycles, pixel_ready for 68, en_array high for 8+4.
  - conv_valid on cycle 84 after start (conv_ready=1).
  - flush and done high on cycle 85; busy low on cycle 86.
- Same setup with pixel_valid deasserted for 5 cycles mid-RUN:
  - en_array and en_cnt are 0 for exactly those 5 cycles.
  - conv_valid is delayed by 5 cycles.
  - With CONV_CTRL_PERF_EN defined, stall_cnt=5.
- conv_ready held low for 10 cycles in OUT:
  - conv_valid stays high for 11 cycles; flush is single-cycle after acceptance.
- abort during LOAD_P at beat 30:
  - next cycle flush=1, done=0, then IDLE.
  - A subsequent start completes normally.
- start asserted while busy, and abort in IDLE: no state change, done not pulsed.
- rst asserted during RUN:
  - next cycle all outputs 0, busy=0, state IDLE.
  - stall_cnt=0 when CONV_CTRL_PERF_EN is defined.
